// File: rtl/deadlock_watchdog_ctrl.sv
// deadlock_watchdog_ctrl
//
// Watches N_SRC deadlock-monitor block indications. A source that stays
// blocked for cfg_threshold consecutive cycles trips, is queued as pending,
// and is reported one at a time through a valid/ready handshake. Grants go
// round-robin, starting one past the last accepted source. A reported source
// is not reported again until its block indication drops (re-arm).
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high reset
//   enable         watchdog enable; 0 clears counters and pending trips
//   block_sigs     per-source block indication (N_SRC bits)
//   cfg_threshold  consecutive blocked cycles before trip; 0 disables tripping
//   report_valid   report available (high only in REPORT)
//   report_ready   consumer accepts the report
//   report_id      index of the reported source
//   report_cycles  that source's counter, captured at grant
//   deadlock       registered OR of (reported & blocked) sources
//   report_count   saturating count of accepted reports
//
// FSM states
//   state     | meaning
//   ST_IDLE   | no report outstanding; grants a pending source if any
//   ST_REPORT | report_id/report_cycles held until report_ready
module deadlock_watchdog_ctrl #(
    parameter int N_SRC = 4,
    parameter int CNT_W = 16,
    parameter int ID_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [N_SRC-1:0]  block_sigs,
    input  logic [CNT_W-1:0]  cfg_threshold,
    output logic              report_valid,
    input  logic              report_ready,
    output logic [ID_W-1:0]   report_id,
    output logic [CNT_W-1:0]  report_cycles,
    output logic              deadlock,
    output logic [7:0]        report_count
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [N_SRC-1:0] block_q;
    logic [N_SRC-1:0] pending, pending_nxt;
    logic [N_SRC-1:0] reported, reported_nxt;
    logic [N_SRC-1:0] trip;
    logic [CNT_W-1:0] cnt     [N_SRC];
    logic [CNT_W-1:0] cnt_inc [N_SRC];
    logic [ID_W-1:0]  rr_ptr;

    logic             grant_vld;
    logic [ID_W-1:0]  grant_id;
    logic             grant_fire;
    logic             accept;

    logic             hi_vld;
    logic [ID_W-1:0]  hi_id;
    logic [ID_W-1:0]  any_id;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (grant_vld)    state_nxt = ST_REPORT;
            ST_REPORT: if (report_ready) state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        report_valid = 1'b0;
        if (state == ST_REPORT) begin
            report_valid = 1'b1;
        end
    end

    assign grant_fire = (state == ST_IDLE) && grant_vld;
    assign accept     = (state == ST_REPORT) && report_ready;

    // ---------------------------------------------------------------------
    // Round-robin arbiter over pending[]: lowest pending index at or above
    // rr_ptr wins, otherwise the lowest pending index overall (wrap).
    // Descending loops let the lowest matching index overwrite last.
    // ---------------------------------------------------------------------
    always_comb begin
        grant_vld = 1'b0;
        hi_vld    = 1'b0;
        hi_id     = '0;
        any_id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_vld = 1'b1;
                any_id    = ID_W'(i);
                if (ID_W'(i) >= rr_ptr) begin
                    hi_vld = 1'b1;
                    hi_id  = ID_W'(i);
                end
            end
        end
        grant_id = hi_vld ? hi_id : any_id;
    end

    // ---------------------------------------------------------------------
    // Per-source counters, trip detection, pending and re-arm bookkeeping.
    // The trip compare uses the count including the current blocked cycle,
    // so an uncontended report carries report_cycles == cfg_threshold.
    // A source is never re-queued while it is the one being granted or
    // the one held in REPORT.
    // ---------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            cnt_inc[i] = (cnt[i] == '1) ? cnt[i] : cnt[i] + CNT_W'(1);

            trip[i] = enable && block_q[i] && (cfg_threshold != '0) &&
                      (cnt_inc[i] >= cfg_threshold) && !reported[i] &&
                      !((state == ST_REPORT) && (report_id == ID_W'(i))) &&
                      !(grant_fire && (grant_id == ID_W'(i)));

            if (!block_q[i] || !enable) begin
                pending_nxt[i] = 1'b0;
            end else if (trip[i]) begin
                pending_nxt[i] = 1'b1;
            end else begin
                pending_nxt[i] = pending[i];
            end
            if (grant_fire && (grant_id == ID_W'(i))) begin
                pending_nxt[i] = 1'b0;
            end

            // Re-arm takes priority: a source that unblocked while its
            // report was in flight must not come back as already reported.
            if (!block_q[i]) begin
                reported_nxt[i] = 1'b0;
            end else if (accept && (report_id == ID_W'(i))) begin
                reported_nxt[i] = 1'b1;
            end else begin
                reported_nxt[i] = reported[i];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            block_q       <= '0;
            pending       <= '0;
            reported      <= '0;
            rr_ptr        <= '0;
            report_id     <= '0;
            report_cycles <= '0;
            report_count  <= '0;
            deadlock      <= 1'b0;
            for (int i = 0; i < N_SRC; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            block_q  <= block_sigs;
            pending  <= pending_nxt;
            reported <= reported_nxt;
            deadlock <= |(reported & block_q);

            for (int i = 0; i < N_SRC; i++) begin
                if (!block_q[i] || !enable) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt_inc[i];
                end
            end

            if (grant_fire) begin
                report_id     <= grant_id;
                report_cycles <= cnt[grant_id];
            end

            if (accept) begin
                rr_ptr <= (report_id == ID_W'(N_SRC - 1)) ? '0 : report_id + ID_W'(1);
                if (report_count != 8'hFF) begin
                    report_count <= report_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_deadlock_watchdog_ctrl.sv
module tb_deadlock_watchdog_ctrl;

    localparam int N_SRC = 4;
    localparam int CNT_W = 16;
    localparam int ID_W  = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic [N_SRC-1:0]  block_sigs;
    logic [CNT_W-1:0]  cfg_threshold;
    logic              report_valid;
    logic              report_ready;
    logic [ID_W-1:0]   report_id;
    logic [CNT_W-1:0]  report_cycles;
    logic              deadlock;
    logic [7:0]        report_count;

    deadlock_watchdog_ctrl #(.N_SRC(N_SRC), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .block_sigs    (block_sigs),
        .cfg_threshold (cfg_threshold),
        .report_valid  (report_valid),
        .report_ready  (report_ready),
        .report_id     (report_id),
        .report_cycles (report_cycles),
        .deadlock      (deadlock),
        .report_count  (report_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] cycles;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   valid_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int id, input int cyc);
        exp_t x;
        x.id     = ID_W'(id);
        x.cycles = CNT_W'(cyc);
        sb.push_back(x);
    endtask

    // Monitor: every cycle a report is presented it must match the head of
    // the scoreboard (this also proves stability while report_ready is low).
    always @(negedge clock) begin
        if (!reset && report_valid) begin
            valid_cycles++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_report: got id %0d cycles %0d, expected no report",
                         report_id, report_cycles);
            end else begin
                check("report_id", 32'(report_id), 32'(sb[0].id));
                check("report_cycles", 32'(report_cycles), 32'(sb[0].cycles));
                if (report_ready) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        enable        = 1'b0;
        block_sigs    = '0;
        cfg_threshold = '0;
        report_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc, input string name);
        int k;
        k = 0;
        while (!report_valid && k < max_cyc) begin
            tick();
            k++;
        end
        n_cmp++;
        if (!report_valid) begin
            n_bad++;
            $display("FAIL %s: report_valid 0 after %0d cycles, expected 1", name, max_cyc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int v0;

        // ---- reset state -------------------------------------------------
        do_reset();
        check("rst_valid",  32'(report_valid),  0);
        check("rst_id",     32'(report_id),     0);
        check("rst_cycles", 32'(report_cycles), 0);
        check("rst_dead",   32'(deadlock),      0);
        check("rst_count",  32'(report_count),  0);

        // ---- single source, T=3, ready high ------------------------------
        cfg_threshold = 16'd3;
        enable        = 1'b1;
        report_ready  = 1'b1;
        tick();
        block_sigs = 4'b0001;
        push_exp(0, 3);
        for (int e = 1; e <= 7; e++) begin
            tick();
            check("A_valid", 32'(report_valid), 32'(e == 5));
            check("A_count", 32'(report_count), 32'(e >= 6));
            check("A_dead",  32'(deadlock),     32'(e >= 7));
        end
        repeat (4) tick();
        check("A_no_dup", 32'(report_valid), 0);
        block_sigs = 4'b0000;
        repeat (3) tick();
        check("A_dead_clear", 32'(deadlock), 0);

        // ---- transient block of 2 cycles never trips ---------------------
        do_reset();
        cfg_threshold = 16'd3;
        enable        = 1'b1;
        report_ready  = 1'b1;
        tick();
        block_sigs = 4'b0001;
        tick();
        tick();
        block_sigs = 4'b0000;
        v0 = valid_cycles;
        repeat (10) tick();
        check("B_no_report", 32'(valid_cycles - v0), 0);
        // counter must have returned to 0: a fresh hold trips with cycles=3
        block_sigs = 4'b0001;
        push_exp(0, 3);
        for (int e = 1; e <= 6; e++) begin
            tick();
            check("B_valid", 32'(report_valid), 32'(e == 5));
        end
        check("B_count", 32'(report_count), 1);

        // ---- simultaneous trips, round-robin 0,1,3 ----------------------
        do_reset();
        cfg_threshold = 16'd2;
        enable        = 1'b1;
        report_ready  = 1'b1;
        tick();
        block_sigs = 4'b1011;
        push_exp(0, 2);
        push_exp(1, 4);
        push_exp(3, 6);
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("C_valid", 32'(report_valid), 32'(e == 4 || e == 6 || e == 8));
            check("C_count", 32'(report_count),
                  (e >= 9) ? 3 : (e >= 7) ? 2 : (e >= 5) ? 1 : 0);
        end

        // ---- back-pressure, no duplicate, re-arm -------------------------
        do_reset();
        cfg_threshold = 16'd2;
        enable        = 1'b1;
        report_ready  = 1'b0;
        tick();
        block_sigs = 4'b0100;
        push_exp(2, 2);
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("D_valid", 32'(report_valid), 32'(e == 4));
        end
        repeat (9) tick();
        check("D_held", 32'(report_valid), 1);
        report_ready = 1'b1;
        tick();
        check("D_accepted", 32'(report_valid), 0);
        check("D_count1",   32'(report_count), 1);
        v0 = valid_cycles;
        repeat (10) tick();
        check("D_no_dup", 32'(valid_cycles - v0), 0);
        block_sigs = 4'b0000;
        tick();
        tick();
        block_sigs = 4'b0100;
        push_exp(2, 2);
        wait_valid(8, "D_rearm_timeout");
        tick();
        check("D_count2", 32'(report_count), 2);

        // ---- threshold 0, enable 0, reset during REPORT ------------------
        do_reset();
        cfg_threshold = 16'd0;
        enable        = 1'b1;
        report_ready  = 1'b1;
        block_sigs    = 4'b1111;
        v0 = valid_cycles;
        repeat (100) tick();
        check("E_t0_report", 32'(valid_cycles - v0), 0);
        check("E_t0_dead",   32'(deadlock),          0);
        cfg_threshold = 16'd2;
        enable        = 1'b0;
        repeat (100) tick();
        check("E_en0_report", 32'(valid_cycles - v0), 0);
        check("E_en0_dead",   32'(deadlock),          0);
        report_ready = 1'b0;
        enable       = 1'b1;
        push_exp(0, 2);
        wait_valid(6, "E_report_timeout");
        tick();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        check("E_abort_valid", 32'(report_valid), 0);
        check("E_abort_count", 32'(report_count), 0);
        sb.delete();
        reset = 1'b0;
        repeat (3) tick();
        check("E_after_valid", 32'(report_valid), 0);
        check("E_after_count", 32'(report_count), 0);

        check("sb_leftover", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
